// File: rtl/sdram_port_arbiter_if.sv
// One client port of sdram_port_arbiter: a stb/ack request channel towards the
// arbiter and a stb/ack response channel back to the client.
interface sdram_port_arbiter_if #(
   parameter int ADR_W  = 24,
   parameter int DATA_W = 16
);
   logic              i_stb;
   logic              i_ack;
   logic              we;
   logic [ADR_W-1:0]  adr;
   logic [DATA_W-1:0] wdata;
   logic              o_stb;
   logic              o_ack;
   logic [DATA_W-1:0] rdata;
   logic              o_err;

   modport master (
      output i_stb, we, adr, wdata, o_ack,
      input  i_ack, o_stb, rdata, o_err
   );

   modport slave (
      input  i_stb, we, adr, wdata, o_ack,
      output i_ack, o_stb, rdata, o_err
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM_Controller read/write command path
// between two clients, one transaction in flight, guarded by a watchdog.
module sdram_port_arbiter #(
   parameter int ADR_W   = 24,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic               CLK,
   input  logic               RST,
   sdram_port_arbiter_if.slave pA,
   sdram_port_arbiter_if.slave pB,
   output logic               rd_i_stb,
   input  logic               rd_i_ack,
   output logic               wt_i_stb,
   input  logic               wt_i_ack,
   output logic [ADR_W-1:0]   sd_adr,
   output logic [DATA_W-1:0]  sd_wdata,
   input  logic               rd_o_stb,
   input  logic               wt_o_stb,
   output logic               sd_o_ack,
   input  logic [DATA_W-1:0]  sd_rdata,
   output logic               busy,
   output logic               owner
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t            state;
   logic              owner_q;
   logic              we_q;
   logic [ADR_W-1:0]  adr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              a_o_stb_q;
   logic              b_o_stb_q;
   logic              rd_stb_q;
   logic              wt_stb_q;
   logic              sd_ack_q;
   logic [15:0]       tmo_cnt;

   logic grant_a;
   logic grant_b;
   logic issued;
   logic rd_done;
   logic wt_done;
   logic expire;
   logic finish;

   // On a tie the port that did not win last time is granted; owner resets to B
   // so A wins the very first tie.
   assign grant_a = RST && (state == IDLE) && pA.i_stb && (!pB.i_stb || owner_q);
   assign grant_b = RST && (state == IDLE) && pB.i_stb && (!pA.i_stb || !owner_q);

   // NOTE: every signal written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      issued  = 1'b0;
      rd_done = 1'b0;
      wt_done = 1'b0;
      expire  = 1'b0;
      if (state == ISSUE) begin
         issued = (rd_stb_q && rd_i_ack) || (wt_stb_q && wt_i_ack);
         expire = !issued && (tmo_cnt >= TMO_LAST);
      end else if (state == WAIT) begin
         // A completion of the wrong type is acked by sd_o_ack but ignored.
         rd_done = !we_q && rd_o_stb;
         wt_done = we_q && wt_o_stb;
         expire  = !rd_done && !wt_done && (tmo_cnt >= TMO_LAST);
      end
      finish = rd_done || wt_done || expire;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of the others regardless of order.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= IDLE;
         owner_q   <= 1'b1;
         we_q      <= 1'b0;
         adr_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         a_o_stb_q <= 1'b0;
         b_o_stb_q <= 1'b0;
         rd_stb_q  <= 1'b0;
         wt_stb_q  <= 1'b0;
         sd_ack_q  <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_a || grant_b) begin
                  owner_q  <= grant_b;
                  we_q     <= grant_b ? pB.we    : pA.we;
                  adr_q    <= grant_b ? pB.adr   : pA.adr;
                  wdata_q  <= grant_b ? pB.wdata : pA.wdata;
                  rd_stb_q <= grant_b ? !pB.we   : !pA.we;
                  wt_stb_q <= grant_b ? pB.we    : pA.we;
                  tmo_cnt  <= '0;
                  state    <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               tmo_cnt <= tmo_cnt + 16'd1;
               if (issued) begin
                  rd_stb_q <= 1'b0;
                  wt_stb_q <= 1'b0;
                  sd_ack_q <= 1'b1;
                  state    <= WAIT;
               end else if (finish) begin
                  rd_stb_q  <= 1'b0;
                  wt_stb_q  <= 1'b0;
                  sd_ack_q  <= 1'b0;
                  rdata_q   <= rd_done ? sd_rdata : '0;
                  err_q     <= expire;
                  a_o_stb_q <= !owner_q;
                  b_o_stb_q <= owner_q;
                  state     <= RESP;
               end
            end
            RESP: begin
               if ((a_o_stb_q && pA.o_ack) || (b_o_stb_q && pB.o_ack)) begin
                  a_o_stb_q <= 1'b0;
                  b_o_stb_q <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pA.i_ack = grant_a;
   assign pB.i_ack = grant_b;
   assign pA.o_stb = a_o_stb_q;
   assign pB.o_stb = b_o_stb_q;
   assign pA.rdata = owner_q ? '0 : rdata_q;
   assign pB.rdata = owner_q ? rdata_q : '0;
   assign pA.o_err = !owner_q && err_q;
   assign pB.o_err = owner_q && err_q;

   assign rd_i_stb = rd_stb_q;
   assign wt_i_stb = wt_stb_q;
   assign sd_adr   = adr_q;
   assign sd_wdata = wdata_q;
   assign sd_o_ack = sd_ack_q;
   assign busy     = (state != IDLE);
   assign owner    = owner_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: two client models, a behavioural
// SDRAM controller, and expected responses queued at grant time.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

   localparam int ADR_W   = 24;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 8;

   typedef struct packed {
      logic              we;
      logic [ADR_W-1:0]  adr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } rsp_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   logic              rd_i_stb, wt_i_stb, sd_o_ack, busy, owner;
   logic              rd_i_ack, wt_i_ack, rd_o_stb, wt_o_stb;
   logic [ADR_W-1:0]  sd_adr;
   logic [DATA_W-1:0] sd_wdata;
   logic [DATA_W-1:0] sd_rdata;

   // Client-side views of the two ports, indexable by port number (0 = A).
   logic [1:0]        c_i_stb;
   logic [1:0]        c_we;
   logic [ADR_W-1:0]  c_adr   [2];
   logic [DATA_W-1:0] c_wdata [2];
   wire  [1:0]        c_i_ack;
   wire  [1:0]        c_o_stb;
   wire  [1:0]        c_o_err;
   wire  [DATA_W-1:0] c_rdata [2];

   req_t req_q   [2][$];
   rsp_t exp_rsp [2][$];
   req_t exp_cmd [$];
   int   grant_log [$];

   bit ctrl_never_ack = 1'b0;
   bit ctrl_hold_resp = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   sdram_port_arbiter_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) pa_if ();
   sdram_port_arbiter_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) pb_if ();

   assign pa_if.i_stb = c_i_stb[0];
   assign pa_if.we    = c_we[0];
   assign pa_if.adr   = c_adr[0];
   assign pa_if.wdata = c_wdata[0];
   assign pa_if.o_ack = 1'b1;
   assign pb_if.i_stb = c_i_stb[1];
   assign pb_if.we    = c_we[1];
   assign pb_if.adr   = c_adr[1];
   assign pb_if.wdata = c_wdata[1];
   assign pb_if.o_ack = 1'b1;

   assign c_i_ack[0] = pa_if.i_ack;
   assign c_i_ack[1] = pb_if.i_ack;
   assign c_o_stb[0] = pa_if.o_stb;
   assign c_o_stb[1] = pb_if.o_stb;
   assign c_o_err[0] = pa_if.o_err;
   assign c_o_err[1] = pb_if.o_err;
   assign c_rdata[0] = pa_if.rdata;
   assign c_rdata[1] = pb_if.rdata;

   sdram_port_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .pA       (pa_if),
      .pB       (pb_if),
      .rd_i_stb (rd_i_stb),
      .rd_i_ack (rd_i_ack),
      .wt_i_stb (wt_i_stb),
      .wt_i_ack (wt_i_ack),
      .sd_adr   (sd_adr),
      .sd_wdata (sd_wdata),
      .rd_o_stb (rd_o_stb),
      .wt_o_stb (wt_o_stb),
      .sd_o_ack (sd_o_ack),
      .sd_rdata (sd_rdata),
      .busy     (busy),
      .owner    (owner)
   );

   always #5 CLK = ~CLK;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Contents of the modelled SDRAM.
   function automatic logic [DATA_W-1:0] mem_data(input logic [ADR_W-1:0] a);
      return (a == 24'h000123) ? 16'hBEEF : (a[15:0] ^ 16'h3C5A);
   endfunction

   task automatic push_req(input int p, input logic we, input logic [ADR_W-1:0] adr,
                           input logic [DATA_W-1:0] wd);
      req_t r;
      r.we    = we;
      r.adr   = adr;
      r.wdata = wd;
      req_q[p].push_back(r);
   endtask

   function automatic bit all_done();
      return (req_q[0].size() == 0) && (req_q[1].size() == 0) &&
             (exp_rsp[0].size() == 0) && (exp_rsp[1].size() == 0) && !busy;
   endfunction

   task automatic wait_idle(input int budget);
      bit done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         @(negedge CLK);
         done = all_done();
      end
      check("idle_reached", 32'(done), 32'd1);
   endtask

   task automatic reset_checks();
      check("rst_busy",     32'(busy),       32'd0);
      check("rst_owner",    32'(owner),      32'd1);
      check("rst_rd_stb",   32'(rd_i_stb),   32'd0);
      check("rst_wt_stb",   32'(wt_i_stb),   32'd0);
      check("rst_sd_o_ack", 32'(sd_o_ack),   32'd0);
      check("rst_sd_adr",   32'(sd_adr),     32'd0);
      check("rst_sd_wdata", 32'(sd_wdata),   32'd0);
      check("rst_o_stb",    32'(c_o_stb),    32'd0);
      check("rst_i_ack",    32'(c_i_ack),    32'd0);
      check("rst_o_err",    32'(c_o_err),    32'd0);
      check("rst_rdata_a",  32'(c_rdata[0]), 32'd0);
      check("rst_rdata_b",  32'(c_rdata[1]), 32'd0);
   endtask

   task automatic apply_reset();
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      reset_checks();
      @(posedge CLK); #1;
      RST = 1'b1;
   endtask

   // Clients: drive requests just after the edge, observe handshakes at negedge.
   initial begin : clients
      bit   hs    [2];
      bit   pulse [2];
      req_t r;
      rsp_t e;
      c_i_stb = '0;
      c_we    = '0;
      for (int p = 0; p < 2; p++) begin
         c_adr[p]   = '0;
         c_wdata[p] = '0;
         hs[p]      = 1'b0;
         pulse[p]   = 1'b0;
      end
      forever begin
         @(posedge CLK); #1;
         for (int p = 0; p < 2; p++) begin
            if (hs[p]) begin
               void'(req_q[p].pop_front());
               hs[p] = 1'b0;
            end
            if (RST && req_q[p].size() > 0) begin
               c_i_stb[p] = 1'b1;
               c_we[p]    = req_q[p][0].we;
               c_adr[p]   = req_q[p][0].adr;
               c_wdata[p] = req_q[p][0].wdata;
            end else begin
               c_i_stb[p] = 1'b0;
            end
         end
         @(negedge CLK);
         if (RST) begin
            for (int p = 0; p < 2; p++) begin
               if (pulse[p]) begin
                  check("ack_pulse", 32'(c_i_ack[p]), 32'd0);
                  pulse[p] = 1'b0;
               end
               if (c_i_stb[p] && c_i_ack[p]) begin
                  hs[p]    = 1'b1;
                  pulse[p] = 1'b1;
                  r = req_q[p][0];
                  grant_log.push_back(p);
                  exp_cmd.push_back(r);
                  e.err   = ctrl_never_ack;
                  e.rdata = (ctrl_never_ack || r.we) ? '0 : mem_data(r.adr);
                  exp_rsp[p].push_back(e);
               end
               if (c_o_stb[p]) begin
                  check("other_o_stb",   32'(c_o_stb[1-p]), 32'd0);
                  check("owner_at_resp", 32'(owner), 32'(p));
                  check("rsp_pending",   32'(exp_rsp[p].size() > 0), 32'd1);
                  if (exp_rsp[p].size() > 0) begin
                     e = exp_rsp[p].pop_front();
                     check("rsp_rdata", 32'(c_rdata[p]), 32'(e.rdata));
                     check("rsp_err",   32'(c_o_err[p]), 32'(e.err));
                  end
               end
            end
         end
      end
   end

   // Behavioural SDRAM controller; the arbiter's outputs toward it are all
   // registered, so sampling and driving at the negedge is race-free.
   initial begin : ctrl_model
      int               cph = 0;
      int               cnt = 0;
      int               dly = 0;
      logic             cur_we = 1'b0;
      logic [ADR_W-1:0] cur_adr = '0;
      req_t             e;
      rd_i_ack = 1'b0;
      wt_i_ack = 1'b0;
      rd_o_stb = 1'b0;
      wt_o_stb = 1'b0;
      sd_rdata = '0;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            rd_i_ack = 1'b0;
            wt_i_ack = 1'b0;
            rd_o_stb = 1'b0;
            wt_o_stb = 1'b0;
            cph      = 0;
            cnt      = 0;
         end else begin
            case (cph)
               0: begin
                  if ((rd_i_stb || wt_i_stb) && !ctrl_never_ack) begin
                     if (cnt >= dly) begin
                        check("cmd_expected", 32'(exp_cmd.size() > 0), 32'd1);
                        if (exp_cmd.size() > 0) begin
                           e = exp_cmd.pop_front();
                           check("cmd_wt_stb", 32'(wt_i_stb), 32'(e.we));
                           check("cmd_rd_stb", 32'(rd_i_stb), 32'(!e.we));
                           check("cmd_adr",    32'(sd_adr),   32'(e.adr));
                           if (e.we) check("cmd_wdata", 32'(sd_wdata), 32'(e.wdata));
                        end
                        rd_i_ack = rd_i_stb;
                        wt_i_ack = wt_i_stb;
                        cur_we   = wt_i_stb;
                        cur_adr  = sd_adr;
                        cph      = 1;
                        cnt      = 0;
                        dly      = $urandom_range(2, 0);
                     end else begin
                        cnt++;
                     end
                  end else begin
                     cnt = 0;
                  end
               end
               1: begin
                  rd_i_ack = 1'b0;
                  wt_i_ack = 1'b0;
                  if (!ctrl_hold_resp) begin
                     if (cnt >= dly) begin
                        sd_rdata = cur_we ? DATA_W'($urandom) : mem_data(cur_adr);
                        if (cur_we) wt_o_stb = 1'b1;
                        else        rd_o_stb = 1'b1;
                        cph = sd_o_ack ? 3 : 2;
                     end else begin
                        cnt++;
                     end
                  end
               end
               2: if (sd_o_ack) cph = 3;
               default: begin
                  rd_o_stb = 1'b0;
                  wt_o_stb = 1'b0;
                  cph      = 0;
                  cnt      = 0;
                  dly      = $urandom_range(2, 0);
               end
            endcase
         end
      end
   end

   initial begin : main
      int  gap;
      int  gaps;
      int  hi;
      bit  seen;
      bit  done;

      // Reset state.
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      reset_checks();
      @(posedge CLK); #1;
      RST = 1'b1;

      // Read on A alone, then a write on B at the top address.
      push_req(0, 1'b0, 24'h000123, 16'h0000);
      wait_idle(100);
      push_req(1, 1'b1, 24'hFFFFFF, 16'h5A5A);
      wait_idle(100);

      // Simultaneous requests right after reset alternate A, B, A, B.
      apply_reset();
      grant_log.delete();
      push_req(0, 1'b0, 24'h000010, 16'h0000);
      push_req(0, 1'b1, 24'h000011, 16'h1111);
      push_req(1, 1'b1, 24'h800020, 16'h2222);
      push_req(1, 1'b0, 24'h800021, 16'h0000);
      wait_idle(200);
      check("sim_grants", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check("sim_order", 32'(grant_log[i]), 32'(i % 2));

      // Back-to-back on A: busy drops for exactly one cycle between grants.
      grant_log.delete();
      push_req(0, 1'b0, 24'h00A000, 16'h0000);
      push_req(0, 1'b1, 24'h00A001, 16'hC0DE);
      push_req(0, 1'b0, 24'h00A002, 16'h0000);
      gap  = 0;
      gaps = 0;
      seen = 1'b0;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge CLK);
         if (busy) begin
            if (seen && gap > 0) begin
               check("b2b_gap", 32'(gap), 32'd1);
               gaps++;
            end
            seen = 1'b1;
            gap  = 0;
         end else if (seen) begin
            gap++;
         end
         done = all_done();
      end
      check("b2b_done",  32'(done), 32'd1);
      check("b2b_gaps",  32'(gaps), 32'd2);
      check("b2b_grants", 32'(grant_log.size()), 32'd3);
      for (int i = 0; i < grant_log.size(); i++)
         check("b2b_port", 32'(grant_log[i]), 32'd0);

      // Timeout: controller never accepts the read.
      ctrl_never_ack = 1'b1;
      push_req(0, 1'b0, 24'h00ABCD, 16'h0000);
      hi   = 0;
      done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge CLK);
         if (rd_i_stb) hi++;
         done = all_done();
      end
      check("to_done",       32'(done), 32'd1);
      check("to_stb_cycles", 32'(hi),   32'(TIMEOUT));
      ctrl_never_ack = 1'b0;
      exp_cmd.delete();

      // Short mixed traffic on both ports.
      for (int i = 0; i < 6; i++)
         push_req(i % 2, 1'($urandom_range(1, 0)), ADR_W'($urandom), DATA_W'($urandom));
      wait_idle(400);

      // Reset while the controller holds the read in WAIT.
      ctrl_hold_resp = 1'b1;
      push_req(0, 1'b0, 24'h000777, 16'h0000);
      done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge CLK);
         done = sd_o_ack;
      end
      check("mid_wait_seen", 32'(done), 32'd1);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      reset_checks();
      exp_rsp[0].delete();
      exp_rsp[1].delete();
      exp_cmd.delete();
      ctrl_hold_resp = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      push_req(0, 1'b0, 24'h000123, 16'h0000);
      wait_idle(100);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester arbiter that shares the single read/write command interface of SDRAM_Controller between two clients, e.g. the UART command path and a second DMA-style client.
- Accepts one stb/ack request per port, serialises requests with round-robin priority, and issues each one to the controller's read or write interface.
- Routes the controller's completion back to the owning port.
- Allows exactly one transaction in flight and guards it with a watchdog timeout.

Parameters:
- ADR_W, 24, SDRAM word address width.
- DATA_W, 16, SDRAM data width.
- TIMEOUT, 1024, cycles allowed from issue to completion before the transaction is aborted (legal range 2..65535).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous and active-low.
- pA_i_stb  in  1  port A request valid.
- pA_i_ack  out  1  port A request accepted.
- pA_we  in  1  port A: 1 = write, 0 = read.
- pA_adr  in  ADR_W  port A address.
- pA_wdata  in  DATA_W  port A write data.
- pA_o_stb  out  1  port A response valid.
- pA_o_ack  in  1  port A response taken.
- pA_rdata  out  DATA_W  port A read data.
- pA_o_err  out  1  port A response is a timeout abort.
- pB_*  same set of ports as port A, for port B.
- rd_i_stb  out  1  to controller read request.
- rd_i_ack  in  1  controller accepted read.
- wt_i_stb  out  1  to controller write request.
- wt_i_ack  in  1  controller accepted write.
- sd_adr  out  ADR_W  to both RD_ADR and WT_ADR.
- sd_wdata  out  DATA_W  to WT_DATA.
- rd_o_stb  in  1  read data valid from controller.
- wt_o_stb  in  1  write complete from controller.
- sd_o_ack  out  1  to both rd_o_ack and wt_o_ack.
- sd_rdata  in  DATA_W  from RD_DATA.
- busy  out  1  a transaction is in flight (state != IDLE).
- owner  out  1  port of the current or last grant (0 = A, 1 = B).

Behaviour:
- Handshake rule, everywhere: a transfer occurs on a rising edge where stb and ack are both high. stb holds its value and its payload until that edge.
- RST low at a clock edge forces:
  - state IDLE;
  - all outputs 0, including every stb, ack, rdata, err and sd_o_ack;
  - owner = 1, so port A wins the first simultaneous request;
  - timeout counter 0.
- Reset in mid-transaction abandons the transaction without completing any handshake. The controller is reset by the same RST, so no cleanup is needed.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any pX_i_stb is high, grant one port: if both are requesting, grant the port != owner; otherwise grant the single requester.
  - Register owner, we, adr and wdata. Pulse the granted pX_i_ack high for exactly 1 cycle, combinationally in IDLE, qualified by the grant. Go to ISSUE.
  - The request is accepted in the same cycle stb is seen. The ungranted port's ack stays 0.
- ISSUE:
  - Drive rd_i_stb (we = 0) or wt_i_stb (we = 1) high, with sd_adr and sd_wdata from the registers.
  - On the matching *_i_ack, drop the stb and go to WAIT.
- WAIT:
  - sd_o_ack is high throughout WAIT.
  - For a read: when rd_o_stb is seen, latch sd_rdata and set err = 0.
  - For a write: when wt_o_stb is seen, set rdata = 0 and err = 0.
  - After either completion, go to RESP.
  - A completion strobe of the non-matching type is acknowledged but ignored.
- RESP:
  - Drive pX_o_stb, pX_rdata and pX_o_err for the owner port only; the other port's o_stb is 0.
  - On pX_o_ack, go to IDLE. A new grant is possible on the following cycle.
- Timeout:
  - The counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT-1 with no completion, drop rd_i_stb/wt_i_stb, go to RESP with err = 1 and rdata = 0.
  - A completion arriving in the same cycle as the timeout wins: normal response, err = 0.
- Minimum latency from pX_i_stb to pX_o_stb is 3 cycles plus the controller's latency.
- A port may hold i_stb during its own RESP. It is not re-granted until IDLE, and it loses to the other port if both are requesting.

Test Plan:
- Read on A alone: A requests read at 0x000123 and the controller returns 0xBEEF → pA_i_ack pulses 1 cycle, rd_i_stb with sd_adr = 0x000123, pA_o_stb with rdata 0xBEEF and err 0, pB_o_stb stays 0.
- Write on B: B writes 0x5A5A to 0xFFFFFF → wt_i_stb with sd_wdata 0x5A5A; after wt_o_stb, pB_o_stb with rdata 0 and err 0.
- Simultaneous requests: A and B held high for 4 transactions after reset → grant order A, B, A, B; owner toggles each time.
- Back-to-back on A only: A requests 3 times with B idle → all 3 granted to A; busy drops for exactly 1 cycle between them.
- Timeout: TIMEOUT = 8 and the controller never asserts rd_i_ack → rd_i_stb drops after 8 cycles; pA_o_stb with err = 1 and rdata = 0.
- Reset mid-transaction: RST low while in WAIT → the next edge gives IDLE, all outputs 0 and owner = 1; after release, a fresh A request completes normally.
